core_sequencer: RTL and testbench

CORE_SEQUENCER -- requirements
Module: core_sequencer

---
 rtl/core_sequencer_pkg.sv | 27 ++
 rtl/core_sequencer_if.sv | 39 +++
 rtl/core_sequencer_perf_counter.sv | 32 +++
 rtl/core_sequencer.sv | 153 +++++++++++++++
 tb/tb_core_sequencer.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// core_sequencer_pkg
//   Core definitions shared by the sequencer and the instruction decoder:
//   phase encodings, PC step, and the word-alignment helper used for
//   branch targets.
// -----------------------------------------------------------------------------
package core_sequencer_pkg;

  // Phase encodings. The decoder keys its behaviour off these values, so
  // they must not be renumbered.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WRITE  = 3'd4
  } state_t;

  localparam logic [31:0] PC_STEP    = 32'd4;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  // Instructions are word aligned; the low two address bits are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// -----------------------------------------------------------------------------
// core_sequencer_if
//   Instruction-memory and data-memory handshake bundle.
//
//   Handshake rule (both channels): the sequencer raises *_req and holds it
//   until it samples *_ack=1 on a rising edge; a transfer happens exactly in
//   a cycle where req=1 and ack=1. An ack seen while req=0 means nothing.
//   imem_data is only meaningful in the imem transfer cycle.
//
//   Signals:
//     imem_req  - instruction fetch request      (master -> slave)
//     imem_ack  - fetch data valid               (slave  -> master)
//     imem_data - fetched instruction word       (slave  -> master)
//     dmem_req  - data memory request            (master -> slave)
//     dmem_ack  - data memory completion         (slave  -> master)
// -----------------------------------------------------------------------------
interface core_sequencer_if;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        dmem_req;
  logic        dmem_ack;

  modport master (
    output imem_req,
    output dmem_req,
    input  imem_ack,
    input  imem_data,
    input  dmem_ack
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    output imem_ack,
    output imem_data,
    output dmem_ack
  );
endinterface

// File: rtl/core_sequencer_perf_counter.sv
// -----------------------------------------------------------------------------
// perf_counter
//   Free-running 64-bit performance counters, both wrapping at 2^64.
//
//   Ports:
//     clk          - core clock
//     rstn         - asynchronous active-low reset, clears both counters
//     instr_retire - high for one cycle per retired instruction
//     cycle_cnt    - cycles elapsed since reset release
//     instret      - instructions retired since reset release
// -----------------------------------------------------------------------------
module perf_counter (
  input  logic        clk,
  input  logic        rstn,
  input  logic        instr_retire,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cycle_cnt <= '0;
      instret   <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
      if (instr_retire) begin
        instret <= instret + 64'd1;
      end
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// -----------------------------------------------------------------------------
// core_sequencer
//   Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> [MEM] ->
//   WRITE -> FETCH. Owns the PC, the latched instruction word and the
//   branch redirect captured in EXEC.
//
//   Parameters:
//     RESET_PC  - PC value loaded on reset
//
//   Ports:
//     clk, rstn  - core clock; asynchronous active-low reset
//     mem        - imem/dmem handshakes (core_sequencer_if.master)
//     state      - current phase (also the FSM debug view), to the decoder
//     pc         - address of the instruction in flight
//     instr_raw  - latched instruction, stable from DECODE through WRITE
//     mem_op     - instruction is a load/store, sampled in EXEC
//     wb_en      - instruction writes rd, sampled in WRITE
//     br_taken   - redirect request, sampled in EXEC
//     br_target  - redirect target, sampled in EXEC (low 2 bits dropped)
//     reg_we     - register-file write strobe
//     cycle_cnt  - cycle counter
//     instret    - retired-instruction counter
//
//   Build option:
//     CORE_PERF_CNT_EN - when defined, cycle_cnt/instret come from a
//                        perf_counter instance; otherwise both are tied to 0.
// -----------------------------------------------------------------------------
module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rstn,
  core_sequencer_if.master        mem,
  output logic [2:0]              state,
  output logic [31:0]             pc,
  output logic [31:0]             instr_raw,
  input  logic                    mem_op,
  input  logic                    wb_en,
  input  logic                    br_taken,
  input  logic [31:0]             br_target,
  output logic                    reg_we,
  output logic [63:0]             cycle_cnt,
  output logic [63:0]             instret
);

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        br_taken_q;
  logic [31:0] br_target_q;

  logic        instr_load;
  logic        br_load;
  logic        pc_load;
  logic [31:0] pc_next;
  logic        imem_req_c;
  logic        dmem_req_c;
  logic        reg_we_c;

  // State register and datapath latches.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
    end else begin
      state_q <= state_d;
      if (instr_load) begin
        instr_q <= mem.imem_data;
      end
      if (br_load) begin
        br_taken_q  <= br_taken;
        br_target_q <= align_word(br_target);
      end
      if (pc_load) begin
        pc_q <= pc_next;
      end
    end
  end

  // Sequential PC: natural 32-bit wrap takes 32'hFFFF_FFFC to 0.
  assign pc_next = br_taken_q ? br_target_q : (pc_q + PC_STEP);

  // Next-state and strobe logic.
  always_comb begin
    state_d    = state_q;
    instr_load = 1'b0;
    br_load    = 1'b0;
    pc_load    = 1'b0;
    imem_req_c = 1'b0;
    dmem_req_c = 1'b0;
    reg_we_c   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_req_c = 1'b1;
        if (mem.imem_ack) begin
          instr_load = 1'b1;
          state_d    = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        br_load = 1'b1;
        state_d = mem_op ? ST_MEM : ST_WRITE;
      end
      ST_MEM: begin
        dmem_req_c = 1'b1;
        if (mem.dmem_ack) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        reg_we_c = wb_en;
        pc_load  = 1'b1;
        state_d  = ST_FETCH;
      end
      // Unreachable encodings 5-7 recover to FETCH with all strobes low.
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Strobes are qualified with rstn so they fall the instant reset asserts
  // and the first fetch request appears only once reset is released.
  assign mem.imem_req = imem_req_c & rstn;
  assign mem.dmem_req = dmem_req_c & rstn;
  assign reg_we       = reg_we_c & rstn;

  assign state     = state_q;
  assign pc        = pc_q;
  assign instr_raw = instr_q;

`ifdef CORE_PERF_CNT_EN
  perf_counter u_perf_counter (
    .clk          (clk),
    .rstn         (rstn),
    .instr_retire (state_q == ST_WRITE),
    .cycle_cnt    (cycle_cnt),
    .instret      (instret)
  );
`else
  assign cycle_cnt = 64'd0;
  assign instret   = 64'd0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// -----------------------------------------------------------------------------
// tb_core_sequencer
//   Directed self-checking bench for core_sequencer. Expected values are
//   hand-computed per scenario; a running exp_pc tracks the architectural PC.
// -----------------------------------------------------------------------------
module tb_core_sequencer;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] ADDI        = 32'h0010_0093;

  // clock / reset
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  core_sequencer_if mif ();

  logic [2:0]  dut_state;
  logic [31:0] pc;
  logic [31:0] instr_raw;
  logic        mem_op;
  logic        wb_en;
  logic        br_taken;
  logic [31:0] br_target;
  logic        reg_we;
  logic [63:0] cycle_cnt;
  logic [63:0] instret;

  core_sequencer #(.RESET_PC(TB_RESET_PC)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .mem       (mif),
    .state     (dut_state),
    .pc        (pc),
    .instr_raw (instr_raw),
    .mem_op    (mem_op),
    .wb_en     (wb_en),
    .br_taken  (br_taken),
    .br_target (br_target),
    .reg_we    (reg_we),
    .cycle_cnt (cycle_cnt),
    .instret   (instret)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_pc;

  // observations filled in by exec_instr
  logic [31:0] obs_trace;
  int          obs_cycles;
  int          obs_imem_req;
  int          obs_dmem_req;
  int          obs_reg_we;
  int          obs_mem_cyc;
  int          obs_strobe_bad;
  int          obs_instr_bad;
  bit          obs_timeout;

  // ---------------------------------------------------------------------------
  // driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mif.imem_ack  = 1'b0;
    mif.imem_data = 32'h0;
    mif.dmem_ack  = 1'b0;
    mem_op        = 1'b0;
    wb_en         = 1'b0;
    br_taken      = 1'b0;
    br_target     = 32'h0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // Runs one instruction starting in FETCH (called #1 after an edge).
  // imem_wait: cycles without ack before the fetch ack.
  // mem_cycles: number of MEM cycles (ack on the last one).
  // Stray acks are driven in every cycle where the matching req should be low.
  task automatic exec_instr(input logic [31:0] data, input logic mem_op_i,
                            input logic wb_en_i, input logic br_i,
                            input logic [31:0] tgt, input int imem_wait,
                            input int mem_cycles);
    logic [31:0] prev_raw;
    logic [3:0]  nib;
    logic [2:0]  st;
    int          fetch_cnt;
    int          mem_cnt;
    bit          done;
    obs_trace = 0; obs_cycles = 0; obs_imem_req = 0; obs_dmem_req = 0;
    obs_reg_we = 0; obs_mem_cyc = 0; obs_strobe_bad = 0; obs_instr_bad = 0;
    obs_timeout = 0;
    fetch_cnt = 0; mem_cnt = 0; done = 0;
    prev_raw = instr_raw;
    while (!done && obs_cycles < 64) begin
      st  = dut_state;
      nib = {1'b0, st} + 4'd1;
      obs_trace = {obs_trace[27:0], nib};
      mif.imem_ack  = 1'b1;
      mif.imem_data = $urandom;
      mif.dmem_ack  = 1'b1;
      mem_op        = 1'($urandom_range(0, 1));
      wb_en         = 1'($urandom_range(0, 1));
      br_taken      = 1'($urandom_range(0, 1));
      br_target     = $urandom;
      case (st)
        3'd0: begin
          if (instr_raw !== prev_raw) obs_instr_bad++;
          if (fetch_cnt == imem_wait) mif.imem_data = data;
          else mif.imem_ack = 1'b0;
          fetch_cnt++;
        end
        3'd2: begin
          mem_op    = mem_op_i;
          br_taken  = br_i;
          br_target = tgt;
        end
        3'd3: begin
          mif.dmem_ack = (mem_cnt == mem_cycles - 1);
          mem_cnt++;
          obs_mem_cyc++;
        end
        3'd4: begin
          wb_en = wb_en_i;
          done  = 1;
        end
        default: ;
      endcase
      if (st != 3'd0 && instr_raw !== data) obs_instr_bad++;
      #1;
      if (mif.imem_req) begin obs_imem_req++; if (st != 3'd0) obs_strobe_bad++; end
      if (mif.dmem_req) begin obs_dmem_req++; if (st != 3'd3) obs_strobe_bad++; end
      if (reg_we)       begin obs_reg_we++;   if (st != 3'd4) obs_strobe_bad++; end
      @(posedge clk);
      #1;
      obs_cycles++;
    end
    if (!done) obs_timeout = 1;
    idle_inputs();
    exp_pc = br_i ? (tgt & 32'hFFFF_FFFC) : (exp_pc + 32'd4);
  endtask

  // ---------------------------------------------------------------------------
  // tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    rstn = 1'b0;
    #1;
    checks++; if (dut_state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", dut_state); end
    checks++; if (pc !== TB_RESET_PC) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc, TB_RESET_PC); end
    checks++; if (instr_raw !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=0", instr_raw); end
    checks++; if ({mif.imem_req, mif.dmem_req, reg_we} !== 3'b000) begin errors++; $display("FAIL reset_strobes got=%b exp=000", {mif.imem_req, mif.dmem_req, reg_we}); end
    checks++; if (cycle_cnt !== 64'd0 || instret !== 64'd0) begin errors++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", cycle_cnt, instret); end
    @(posedge clk); #1;
    rstn = 1'b1;
    #1;
    checks++; if (mif.imem_req !== 1'b1 || dut_state !== 3'd0) begin errors++; $display("FAIL release_imem_req got=%b st=%0d exp=1 st=0", mif.imem_req, dut_state); end
    exp_pc = TB_RESET_PC;
    #(1);
    step();
    // one FETCH cycle has now passed with no ack; stay in FETCH
    checks++; if (dut_state !== 3'd0) begin errors++; $display("FAIL fetch_hold got=%0d exp=0", dut_state); end
  endtask

  task automatic test_alu();
    exec_instr(ADDI, 1'b0, 1'b1, 1'b0, 32'h0, 0, 0);
    checks++; if (obs_timeout) begin errors++; $display("FAIL alu_timeout got=timeout exp=done"); end
    checks++; if (obs_trace !== 32'h0000_1235) begin errors++; $display("FAIL alu_trace got=%h exp=00001235", obs_trace); end
    checks++; if (obs_reg_we !== 1) begin errors++; $display("FAIL alu_reg_we got=%0d exp=1", obs_reg_we); end
    checks++; if (pc !== 32'd4) begin errors++; $display("FAIL alu_pc got=%h exp=00000004", pc); end
    checks++; if (instr_raw !== ADDI) begin errors++; $display("FAIL alu_instr got=%h exp=%h", instr_raw, ADDI); end
    checks++; if (obs_strobe_bad !== 0 || obs_instr_bad !== 0) begin errors++; $display("FAIL alu_hygiene got=%0d/%0d exp=0/0", obs_strobe_bad, obs_instr_bad); end
  endtask

  task automatic test_imem_wait();
    exec_instr(32'hDEAD_0013, 1'b0, 1'b1, 1'b0, 32'h0, 3, 0);
    checks++; if (obs_trace !== 32'h0111_1235) begin errors++; $display("FAIL imem_wait_trace got=%h exp=01111235", obs_trace); end
    checks++; if (obs_imem_req !== 4) begin errors++; $display("FAIL imem_wait_req got=%0d exp=4", obs_imem_req); end
    checks++; if (obs_instr_bad !== 0) begin errors++; $display("FAIL imem_wait_instr got=%0d exp=0", obs_instr_bad); end
    checks++; if (pc !== 32'd8) begin errors++; $display("FAIL imem_wait_pc got=%h exp=00000008", pc); end
  endtask

  task automatic test_mem();
    exec_instr(32'h0000_2003, 1'b1, 1'b1, 1'b0, 32'h0, 0, 2);
    checks++; if (obs_trace !== 32'h0012_3445) begin errors++; $display("FAIL mem_trace got=%h exp=00123445", obs_trace); end
    checks++; if (obs_mem_cyc !== 2 || obs_dmem_req !== 2) begin errors++; $display("FAIL mem_dmem_req got=%0d/%0d exp=2/2", obs_mem_cyc, obs_dmem_req); end
    checks++; if (obs_strobe_bad !== 0) begin errors++; $display("FAIL mem_strobes got=%0d exp=0", obs_strobe_bad); end
    checks++; if (pc !== 32'd12) begin errors++; $display("FAIL mem_pc got=%h exp=0000000c", pc); end
    exec_instr(32'h0000_2023, 1'b1, 1'b0, 1'b0, 32'h0, 0, 1);
    checks++; if (obs_cycles !== 5 || obs_trace !== 32'h0001_2345) begin errors++; $display("FAIL mem_min_latency got=%0d/%h exp=5/00012345", obs_cycles, obs_trace); end
    checks++; if (obs_reg_we !== 0) begin errors++; $display("FAIL store_reg_we got=%0d exp=0", obs_reg_we); end
    checks++; if (pc !== 32'd16) begin errors++; $display("FAIL mem2_pc got=%h exp=00000010", pc); end
  endtask

  task automatic test_reset_mid();
    checks++; if (pc !== 32'd16) begin errors++; $display("FAIL mid_pre_pc got=%h exp=00000010", pc); end
    mif.imem_ack = 1'b1; mif.imem_data = 32'h0000_A003;
    step(); idle_inputs();
    step(); mem_op = 1'b1;
    step(); idle_inputs();
    checks++; if (dut_state !== 3'd3 || mif.dmem_req !== 1'b1) begin errors++; $display("FAIL mid_in_mem got=%0d/%b exp=3/1", dut_state, mif.dmem_req); end
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (mif.dmem_req !== 1'b0 || dut_state !== 3'd0) begin errors++; $display("FAIL mid_async_drop got=%b/%0d exp=0/0", mif.dmem_req, dut_state); end
    checks++; if (pc !== TB_RESET_PC) begin errors++; $display("FAIL mid_pc got=%h exp=%h", pc, TB_RESET_PC); end
    wb_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL mid_reg_we cyc=%0d got=%b exp=0", i, reg_we); end
    end
    @(posedge clk); #1;
    idle_inputs();
    rstn = 1'b1;
    #1;
    checks++; if (mif.imem_req !== 1'b1 || dut_state !== 3'd0) begin errors++; $display("FAIL mid_restart got=%b/%0d exp=1/0", mif.imem_req, dut_state); end
    exp_pc = TB_RESET_PC;
    #1;
    exec_instr(ADDI, 1'b0, 1'b1, 1'b0, 32'h0, 0, 0);
    checks++; if (pc !== 32'd4 || obs_reg_we !== 1) begin errors++; $display("FAIL mid_refetch got=%h/%0d exp=00000004/1", pc, obs_reg_we); end
  endtask

  task automatic test_branch();
    exec_instr(32'h1000_006F, 1'b0, 1'b0, 1'b1, 32'h0000_0103, 0, 0);
    checks++; if (pc !== 32'h0000_0100) begin errors++; $display("FAIL branch_target got=%h exp=00000100", pc); end
    exec_instr(32'hFE00_0EE3, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 0, 0);
    checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL branch_high got=%h exp=fffffffc", pc); end
    exec_instr(ADDI, 1'b0, 1'b1, 1'b0, 32'h0, 0, 0);
    checks++; if (pc !== 32'h0000_0000) begin errors++; $display("FAIL pc_wrap got=%h exp=00000000", pc); end
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL pc_model got=%h exp=%h", pc, exp_pc); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_cyc;
    logic [63:0] exp_ret;
    int          total;
    do_reset();
    exp_pc = TB_RESET_PC;
    total  = 0;
    for (int i = 0; i < 10; i++) begin
      exec_instr(ADDI + 32'(i), 1'b0, 1'b1, 1'b0, 32'h0, 0, 0);
      total += obs_cycles;
    end
`ifdef CORE_PERF_CNT_EN
    exp_cyc = 64'd40;
    exp_ret = 64'd10;
`else
    exp_cyc = 64'd0;
    exp_ret = 64'd0;
`endif
    checks++; if (total !== 40) begin errors++; $display("FAIL b2b_cycles got=%0d exp=40", total); end
    checks++; if (pc !== 32'd40) begin errors++; $display("FAIL b2b_pc got=%h exp=00000028", pc); end
    checks++; if (instret !== exp_ret) begin errors++; $display("FAIL instret got=%0d exp=%0d", instret, exp_ret); end
    checks++; if (cycle_cnt !== exp_cyc) begin errors++; $display("FAIL cycle_cnt got=%0d exp=%0d", cycle_cnt, exp_cyc); end
  endtask

  // ---------------------------------------------------------------------------
  // sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_alu();
    test_imem_wait();
    test_mem();
    test_reset_mid();
    test_branch();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
